// File: rtl/switch_input_port.sv
`timescale 1ns/1ps
// Switch input peripheral: two-flop sync, per-bit debounce, sticky change
// bits and a saturating accepted-change counter behind a small register map.
//
// Ports:
//   clk, reset (sync, active-high)
//   switches_in    raw asynchronous switch pins
//   rd_en/wr_en    bus strobes; addr = byte offset, [1:0] ignored
//   wr_data        bus write data; rd_data = registered read data
//   sw_stable      debounced switch value
//   change_pending OR of all CHANGED bits (registered)
//   irq            |(CHANGED & IRQ_MASK), only with SW_IRQ_EN defined
//
// Register map: 0x00 STATE (RO), 0x04 CHANGED (RO), 0x08 CLEAR (W1C),
//   0x0C EDGE_COUNT (RO, any write clears), 0x10 IRQ_MASK (RW, SW_IRQ_EN).
// Optional feature macro: SW_IRQ_EN.

module switch_input_port #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_in,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic [WIDTH-1:0] sw_stable,
`ifdef SW_IRQ_EN
  output logic             irq,
`endif
  output logic             change_pending
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] changed;
  logic [15:0]      edge_count;

  logic [WIDTH-1:0] accept;
  logic [5:0]       pop;
  logic [2:0]       sel;
  logic             sel_state;
  logic             sel_changed;
  logic             sel_clear;
  logic             sel_count;
  logic             sel_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] changed_nxt;
  logic [16:0]      sum;
  logic [15:0]      edge_nxt;
  logic [31:0]      rd_val;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_nxt;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wr_data, sel_mask};

  assign sel         = addr[4:2];
  assign sel_state   = (sel == 3'd0);
  assign sel_changed = (sel == 3'd1);
  assign sel_clear   = (sel == 3'd2);
  assign sel_count   = (sel == 3'd3);
  assign sel_mask    = (sel == 3'd4);

  // A bit is accepted on the cycle its counter has already seen
  // DEBOUNCE_CYCLES-1 differing samples and the sample still differs.
  always_comb begin
    accept = '0;
    pop    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != sw_stable[i]) && (cnt[i] == LAST);
      pop       = pop + 6'(accept[i]);
    end
  end

  // New acceptances win over a same-cycle clear.
  assign clr_mask    = (wr_en && sel_clear) ? wr_data[WIDTH-1:0] : '0;
  assign changed_nxt = (changed & ~clr_mask) | accept;

  assign sum      = {1'b0, edge_count} + 17'(pop);
  assign edge_nxt = (wr_en && sel_count) ? 16'(pop)
                  : (sum[16] ? 16'hFFFF : sum[15:0]);

`ifdef SW_IRQ_EN
  assign mask_nxt = (wr_en && sel_mask) ? wr_data[WIDTH-1:0] : mask_q;
`else
  assign mask_nxt = '0;
`endif

  // Read mux uses current (pre-write) register contents.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_state:   rd_val = 32'(sw_stable);
      sel_changed: rd_val = 32'(changed);
      sel_count:   rd_val = 32'(edge_count);
`ifdef SW_IRQ_EN
      sel_mask:    rd_val = 32'(mask_q);
`endif
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1          <= '0;
      sync2          <= '0;
      sw_stable      <= '0;
      changed        <= '0;
      edge_count     <= '0;
      rd_data        <= '0;
      change_pending <= 1'b0;
      mask_q         <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= switches_in;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          sw_stable[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      changed        <= changed_nxt;
      edge_count     <= edge_nxt;
      change_pending <= |changed_nxt;
      mask_q         <= mask_nxt;
      if (rd_en) rd_data <= rd_val;
    end
  end

`ifdef SW_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(changed_nxt & mask_nxt);
  end
`endif

endmodule

// File: tb/tb_switch_input_port.sv
`timescale 1ns/1ps
// Directed bench for switch_input_port (default WIDTH=10, DEBOUNCE=4).
// Hand-computed expectations; one check task, one summary line.

module tb_switch_input_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  switches_in;
  logic        rd_en;
  logic        wr_en;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [9:0]  sw_stable;
  logic        change_pending;
`ifdef SW_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] rv;
  logic [9:0]  sw;

  switch_input_port dut (
    .clk            (clk),
    .reset          (reset),
    .switches_in    (switches_in),
    .rd_en          (rd_en),
    .wr_en          (wr_en),
    .addr           (addr),
    .wr_data        (wr_data),
    .rd_data        (rd_data),
    .sw_stable      (sw_stable),
`ifdef SW_IRQ_EN
    .irq            (irq),
`endif
    .change_pending (change_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    addr  = a;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    d     = rd_data;
  endtask

  initial begin
    reset       = 1'b1;
    switches_in = 10'd4;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    addr        = '0;
    wr_data     = '0;
    tick(2);
    check("rst_stable", 32'(sw_stable), 32'h0);
    check("rst_rd", rd_data, 32'h0);
    check("rst_pend", 32'(change_pending), 32'h0);
    reset = 1'b0;

    // Edges 0..4 after release: not yet accepted; edge 5 accepts.
    tick(5);
    check("lat_before", 32'(sw_stable), 32'h0);
    tick(1);
    check("lat_after", 32'(sw_stable), 32'h4);
    check("lat_pend", 32'(change_pending), 32'h1);
    tick(14);
    bus_read(5'h04, rv);
    check("changed0", rv, 32'h004);
    bus_read(5'h0C, rv);
    check("count0", rv, 32'd1);

    // Three-cycle glitch on bit 0 must be rejected.
    switches_in = 10'd5;
    tick(3);
    switches_in = 10'd4;
    tick(10);
    check("glitch_st", 32'(sw_stable), 32'h4);
    bus_read(5'h04, rv);
    check("glitch_chg", rv, 32'h004);
    bus_read(5'h0C, rv);
    check("glitch_cnt", rv, 32'd1);

    // All high: nine bits accepted in one cycle.
    switches_in = 10'h3FF;
    tick(10);
    bus_read(5'h00, rv);
    check("state_3ff", rv, 32'h3FF);
    tick(3);
    check("rd_hold", rd_data, 32'h3FF);
    bus_read(5'h0C, rv);
    check("count9", rv, 32'd10);
    bus_read(5'h04, rv);
    check("changed_all", rv, 32'h3FF);
    bus_read(5'h08, rv);
    check("clear_rd0", rv, 32'h0);
    bus_read(5'h10, rv);
    check("off10_rd", rv, 32'h0);
    bus_read(5'h14, rv);
    check("unmapped", rv, 32'h0);

    bus_write(5'h00, 32'h0);
    check("ro_write", 32'(sw_stable), 32'h3FF);
    bus_write(5'h08, 32'h3FF);
    check("clr_pend", 32'(change_pending), 32'h0);
    bus_read(5'h04, rv);
    check("clr_all", rv, 32'h0);

    // Bit 2 accepted on the same edge as its W1C: set wins.
    switches_in = 10'h3FB;
    tick(5);
    bus_write(5'h08, 32'h004);
    check("w1c_race_st", 32'(sw_stable), 32'h3FB);
    check("w1c_race_p", 32'(change_pending), 32'h1);
    bus_read(5'h04, rv);
    check("w1c_race", rv, 32'h004);
    bus_write(5'h08, 32'h004);
    check("w1c_pend", 32'(change_pending), 32'h0);
    bus_read(5'h04, rv);
    check("w1c_done", rv, 32'h0);

    // Read and clear in the same cycle returns the pre-write value.
    addr    = 5'h0C;
    wr_data = 32'h0;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    tick(1);
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    check("rdwr_old", rd_data, 32'd11);
    bus_read(5'h0C, rv);
    check("rdwr_clr", rv, 32'd0);

`ifdef SW_IRQ_EN
    bus_write(5'h10, 32'h001);
    bus_read(5'h10, rv);
    check("mask_rd", rv, 32'h001);
    sw = switches_in ^ 10'h002;
    switches_in = sw;
    tick(6);
    check("irq_masked", 32'(irq), 32'h0);
    sw = switches_in ^ 10'h001;
    switches_in = sw;
    tick(6);
    check("irq_set", 32'(irq), 32'h1);
    bus_write(5'h08, 32'h001);
    check("irq_clr", 32'(irq), 32'h0);
    bus_write(5'h0C, 32'h0);
`endif

    // Saturation: 6553 full toggles -> 65530, then 3-bit steps.
    sw = switches_in;
    for (int t = 0; t < 6553; t++) begin
      sw = ~sw;
      switches_in = sw;
      tick(6);
    end
    bus_read(5'h0C, rv);
    check("cnt_65530", rv, 32'd65530);
    sw = sw ^ 10'h007;
    switches_in = sw;
    tick(6);
    bus_read(5'h0C, rv);
    check("cnt_fffd", rv, 32'hFFFD);
    sw = sw ^ 10'h007;
    switches_in = sw;
    tick(6);
    bus_read(5'h0C, rv);
    check("cnt_sat", rv, 32'hFFFF);
    sw = sw ^ 10'h007;
    switches_in = sw;
    tick(6);
    bus_read(5'h0C, rv);
    check("cnt_sat2", rv, 32'hFFFF);
    bus_write(5'h0C, 32'h1234);
    bus_read(5'h0C, rv);
    check("cnt_wclr", rv, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
